timer_counter: RTL and testbench

- Memory-mapped 32-bit timer/counter device on the data-side bus, directly downstream of the CPU MEM stage.
- Consumes the MEM-stage store/load traffic (address, write enable, write data) that otherwise targets DM, and returns read data combinationally.
- Counts down from a software-loaded preset and raises an interrupt request to the CPU.
- Clocked on the same edge as DM; at integration clk is driven with clk_re.

---
 rtl/timer_counter_pkg.sv | 25 ++
 rtl/timer_counter.sv | 96 +++++++++
 tb/tb_timer_counter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/timer_counter_pkg.sv
// rtl/timer_counter_pkg.sv - register map, CTRL fields, mode codes and FSM states
package timer_counter_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'b00;
  localparam logic [1:0] ADDR_PRESET = 2'b01;
  localparam logic [1:0] ADDR_COUNT  = 2'b10;
  localparam logic [1:0] ADDR_RSVD   = 2'b11;

  localparam int CTRL_W       = 4;
  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_CNT  = 2'b10,
    ST_INT  = 2'b11
  } state_t;

endpackage

// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - memory-mapped down-counting timer with interrupt request
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         addr,
  input  logic               we,
  input  logic [COUNT_W-1:0] wd,
  output logic [COUNT_W-1:0] rd,
  output logic               irq
);

  state_t              r_state, w_state_nxt;
  logic [CTRL_W-1:0]   r_ctrl, w_ctrl_nxt;
  logic [COUNT_W-1:0]  r_preset;
  logic [COUNT_W-1:0]  r_count, w_count_nxt;
  logic                r_irq_pending, w_pending_nxt;
  logic                w_ctrl_wr, w_preset_wr, w_en, w_reload;

  assign w_ctrl_wr   = we && (addr == ADDR_CTRL);
  assign w_preset_wr = we && (addr == ADDR_PRESET);
  assign w_en        = r_ctrl[CTRL_EN];
  assign w_reload    = (r_ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);

  always_comb begin
    w_state_nxt   = r_state;
    w_ctrl_nxt    = r_ctrl;
    w_count_nxt   = r_count;
    w_pending_nxt = r_irq_pending;
    case (r_state)
      ST_IDLE: if (w_en) w_state_nxt = ST_LOAD;
      ST_LOAD: begin
        w_count_nxt = r_preset;
        w_state_nxt = ST_CNT;
      end
      ST_CNT: begin
        if (!w_en) begin
          w_state_nxt = ST_IDLE;
        end else if (r_count > COUNT_W'(1)) begin
          w_count_nxt = r_count - COUNT_W'(1);
        end else begin
          w_count_nxt   = '0;
          w_pending_nxt = 1'b1;
          w_state_nxt   = ST_INT;
        end
      end
      ST_INT: begin
        if (w_reload) begin
          w_pending_nxt = 1'b0;
          w_state_nxt   = ST_LOAD;
        end else begin
          w_ctrl_nxt[CTRL_EN] = 1'b0;
          w_state_nxt         = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // A bus write to CTRL overrides the one-shot EN clear and always drops pending.
    if (w_ctrl_wr) begin
      w_ctrl_nxt    = wd[CTRL_W-1:0];
      w_pending_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_ctrl        <= '0;
      r_preset      <= '0;
      r_count       <= '0;
      r_irq_pending <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_ctrl        <= w_ctrl_nxt;
      r_count       <= w_count_nxt;
      r_irq_pending <= w_pending_nxt;
      if (w_preset_wr) r_preset <= wd;
    end
  end

  always_comb begin
    rd = '0;
    case (addr)
      ADDR_CTRL:   rd = {{(COUNT_W-CTRL_W){1'b0}}, r_ctrl};
      ADDR_PRESET: rd = r_preset;
      ADDR_COUNT:  rd = r_count;
      default:     rd = '0;
    endcase
  end

  assign irq = r_irq_pending & r_ctrl[CTRL_IM];

endmodule

// File: tb/tb_timer_counter.sv
// tb/tb_timer_counter.sv - directed self-checking bench for timer_counter
module tb_timer_counter;
  import timer_counter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        irq;

  int compared = 0;
  int mismatched = 0;

  timer_counter #(.COUNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wd    (wd),
    .rd    (rd),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wd = d;
    step(1);
    we = 1'b0; wd = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic rdchk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, rd, exp);
  endtask

  initial begin
    logic [31:0] ar_count [4];
    logic        ar_irq   [4];
    ar_count[0] = 32'd2; ar_count[1] = 32'd1; ar_count[2] = 32'd0; ar_count[3] = 32'd0;
    ar_irq[0] = 1'b0; ar_irq[1] = 1'b0; ar_irq[2] = 1'b1; ar_irq[3] = 1'b0;

    reset = 1'b1; we = 1'b0; addr = ADDR_CTRL; wd = '0;
    step(2);
    reset = 1'b0;
    rdchk("rst_ctrl", ADDR_CTRL, 32'h0);
    rdchk("rst_preset", ADDR_PRESET, 32'h0);
    rdchk("rst_count", ADDR_COUNT, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    chk("rst_state", 32'(dut.r_state), 32'(ST_IDLE));

    // reset in the middle of counting
    wr(ADDR_PRESET, 32'd8);
    wr(ADDR_CTRL, 32'h9);
    step(2);
    rdchk("mid_cnt8", ADDR_COUNT, 32'd8);
    step(3);
    rdchk("mid_cnt5", ADDR_COUNT, 32'd5);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    rdchk("mid_rst_count", ADDR_COUNT, 32'd0);
    rdchk("mid_rst_ctrl", ADDR_CTRL, 32'd0);
    chk("mid_rst_state", 32'(dut.r_state), 32'(ST_IDLE));
    chk("mid_rst_irq", {31'b0, irq}, 32'h0);
    step(3);
    chk("mid_rst_irq_later", {31'b0, irq}, 32'h0);

    // one-shot, PRESET=3
    wr(ADDR_PRESET, 32'd3);
    wr(ADDR_CTRL, 32'h9);
    step(2);
    rdchk("os_cnt3", ADDR_COUNT, 32'd3);
    chk("os_irq_cnt3", {31'b0, irq}, 32'h0);
    step(1);
    rdchk("os_cnt2", ADDR_COUNT, 32'd2);
    step(1);
    rdchk("os_cnt1", ADDR_COUNT, 32'd1);
    chk("os_irq_cnt1", {31'b0, irq}, 32'h0);
    step(1);
    rdchk("os_cnt0", ADDR_COUNT, 32'd0);
    chk("os_irq_int", {31'b0, irq}, 32'h1);
    step(1);
    rdchk("os_ctrl_after", ADDR_CTRL, 32'h8);
    chk("os_irq_idle", {31'b0, irq}, 32'h1);
    step(2);
    chk("os_irq_hold", {31'b0, irq}, 32'h1);
    rdchk("os_cnt_floor", ADDR_COUNT, 32'd0);
    wr(ADDR_CTRL, 32'h0);
    chk("os_irq_clr", {31'b0, irq}, 32'h0);
    step(2);

    // auto-reload, PRESET=2: period of 4 cycles
    wr(ADDR_PRESET, 32'd2);
    wr(ADDR_CTRL, 32'hB);
    step(1);
    addr = ADDR_COUNT;
    for (int i = 0; i < 12; i++) begin
      step(1);
      chk($sformatf("ar_irq_%0d", i), {31'b0, irq}, {31'b0, ar_irq[i % 4]});
      chk($sformatf("ar_cnt_%0d", i), rd, ar_count[i % 4]);
    end
    wr(ADDR_CTRL, 32'h0);
    step(3);
    chk("ar_stop_irq", {31'b0, irq}, 32'h0);

    // freeze with EN=0, then restart from PRESET
    wr(ADDR_PRESET, 32'd12);
    wr(ADDR_CTRL, 32'h9);
    step(2);
    rdchk("fz_cnt12", ADDR_COUNT, 32'd12);
    step(2);
    rdchk("fz_cnt10", ADDR_COUNT, 32'd10);
    wr(ADDR_CTRL, 32'h8);
    addr = ADDR_COUNT;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk($sformatf("fz_hold_%0d", i), rd, 32'd9);
    end
    wr(ADDR_CTRL, 32'h9);
    step(2);
    rdchk("fz_reload", ADDR_COUNT, 32'd12);
    wr(ADDR_PRESET, 32'd100);
    rdchk("fz_preset_no_effect", ADDR_COUNT, 32'd11);
    wr(ADDR_CTRL, 32'h0);
    step(2);
    rdchk("fz_frozen10", ADDR_COUNT, 32'd10);

    // read-only COUNT, reserved address, CTRL upper bits
    wr(ADDR_COUNT, 32'h1234);
    rdchk("ro_count", ADDR_COUNT, 32'd10);
    wr(ADDR_RSVD, 32'h55);
    rdchk("rsvd_rd", ADDR_RSVD, 32'h0);
    wr(ADDR_CTRL, 32'hFFFF_FFFF);
    rdchk("ctrl_mask", ADDR_CTRL, 32'hF);
    rdchk("ro_count2", ADDR_COUNT, 32'd10);
    wr(ADDR_CTRL, 32'h0);
    step(3);

    // PRESET=0, IM=0, one-shot
    wr(ADDR_PRESET, 32'd0);
    wr(ADDR_CTRL, 32'h1);
    step(1);
    chk("z_load", 32'(dut.r_state), 32'(ST_LOAD));
    step(1);
    chk("z_cnt", 32'(dut.r_state), 32'(ST_CNT));
    step(1);
    chk("z_int", 32'(dut.r_state), 32'(ST_INT));
    chk("z_irq_masked", {31'b0, irq}, 32'h0);
    step(1);
    rdchk("z_en_clear", ADDR_CTRL, 32'h0);
    chk("z_idle", 32'(dut.r_state), 32'(ST_IDLE));
    wr(ADDR_CTRL, 32'h8);
    chk("z_irq_after_im", {31'b0, irq}, 32'h0);
    step(2);
    chk("z_irq_after_im2", {31'b0, irq}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
